pipe_stage_latch: RTL and testbench

- Parametrised inter-stage pipeline latch: generalised successor to the fetch/decode latch.
- Carries an instruction word and its PC between two pipeline stages.
- Adds a valid/ready handshake in both directions, synchronous flush, and an optional 2-entry skid buffer so that in_ready is a registered signal.
- Used between fetch→decode and any later stage boundary that needs back-pressure.

---
 rtl/pipe_stage_latch.sv | 134 +++++++++++++
 tb/tb_pipe_stage_latch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch carrying an instruction word and its PC with valid/ready on both sides.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_latch #(
  parameter int              IW       = 32,
  parameter int              AW       = 32,
  parameter logic [IW-1:0]   NOP_WORD = '0
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc
);

  // Handshake: a beat moves on a rising edge where valid && ready; a producer
  // holding valid keeps its payload stable until ready is seen.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] main_instr_q, main_instr_d;
  logic [AW-1:0] main_pc_q, main_pc_d;
  logic          accept, consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_instr = out_valid ? main_instr_q : NOP_WORD;
  assign out_pc    = out_valid ? main_pc_q : '0;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] ST_SKID = 2'd2;

  logic [IW-1:0] skid_instr_q, skid_instr_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;
  logic          in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_FULL;
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end
      end
      ST_FULL: begin
        if (accept && consume) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d      = ST_SKID;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only the drain of main can happen
        if (consume) begin
          state_d      = ST_FULL;
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= NOP_WORD;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  // Single entry: a full latch can only take a new beat while it is draining.
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    if (accept) begin
      state_d      = ST_FULL;
      main_instr_d = in_instr;
      main_pc_d    = in_pc;
    end else if (consume) begin
      state_d = ST_EMPTY;
    end
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= NOP_WORD;
      main_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: reset, streaming, back-pressure, flush and async reset,
// with an in-order expected queue tracking every accepted beat until it is consumed.
module tb_pipe_stage_latch;
  localparam int IW = 32;
  localparam int AW = 32;
  localparam int W  = IW + AW;

  logic          CLK;
  logic          nRST;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  int checks   = 0;
  int failures = 0;
  int consumed = 0;
  logic [W-1:0] exp_q[$];

  pipe_stage_latch #(.IW(IW), .AW(AW), .NOP_WORD('0)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = 32'hA000_0000 | pc;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [AW-1:0] pc);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_pc"}, 64'(out_pc), 64'(v ? pc : '0));
    chk({tag, "_instr"}, 64'(out_instr), 64'(v ? (32'hA000_0000 | pc) : 32'h0));
  endtask

  // scoreboard: consumes pop in order; a flush discards everything still held
  always @(negedge CLK) begin
    if (nRST) begin
      if (out_valid && out_ready) begin
        chk("sb_pop_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("sb_beat", {out_instr, out_pc}, exp_q.pop_front());
        consumed++;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_instr, in_pc});
    end
  end

  initial begin
    // reset with a beat presented upstream
    nRST = 1'b0;
    in_valid = 1'b1; in_instr = 32'hDEADBEEF; in_pc = 32'h100;
    out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    nRST = 1'b1;
    #1;
    tick();
    chk("rel_out_valid", 64'(out_valid), 64'd1);
    chk("rel_out_instr", 64'(out_instr), 64'hDEADBEEF);
    chk("rel_out_pc", 64'(out_pc), 64'h100);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_out("rel_drain", 1'b0, 32'h0);

    // streaming with no bubbles
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk_out("stream", 1'b1, 32'(i * 4));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_out("stream_end", 1'b0, 32'h0);

    // back-pressure for 3 cycles once 0x04 is on the output
    drive(1'b1, 32'h00, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h04, 1'b1, 1'b0);
    tick();
    chk_out("bp_pre", 1'b1, 32'h04);
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 32'h08, 1'b0, 1'b0);
    chk("bp_c1_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp_c1", 1'b1, 32'h04);
    chk("bp_c1_skid_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0C, 1'b0, 1'b0);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk_out("bp_hold", 1'b1, 32'h04);
    end
    drive(1'b1, 32'h0C, 1'b1, 1'b0);
    chk("bp_r1_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk_out("bp_r1", 1'b1, 32'h08);
`else
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h08, 1'b0, 1'b0);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk_out("bp_hold", 1'b1, 32'h04);
    end
    drive(1'b1, 32'h08, 1'b1, 1'b0);
    chk("bp_r1_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp_r1", 1'b1, 32'h08);
`endif
    drive(1'b1, 32'h0C, 1'b1, 1'b0);
    chk("bp_r2_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp_r2", 1'b1, 32'h0C);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_out("bp_end", 1'b0, 32'h0);

    // flush with main 0x10, 0x14 waiting, 0x18 offered
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    chk_out("fl_main", 1'b1, 32'h10);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h18, 1'b0, 1'b1);
    tick();
    chk_out("fl_after", 1'b0, 32'h0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_out("fl_quiet1", 1'b0, 32'h0);
    tick();
    chk_out("fl_quiet2", 1'b0, 32'h0);

    // flush and consume on the same edge, with a beat offered that must be dropped
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    tick();
    chk_out("fc_main", 1'b1, 32'h20);
    drive(1'b1, 32'h24, 1'b1, 1'b1);
    tick();
    chk_out("fc_after", 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_out("fc_nodup", 1'b0, 32'h0);

    // asynchronous reset between edges while holding two beats
    drive(1'b1, 32'h30, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h34, 1'b0, 1'b0);
    tick();
    chk_out("ar_pre", 1'b1, 32'h30);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    nRST = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_out_instr", 64'(out_instr), 64'd0);
    chk("ar_out_pc", 64'(out_pc), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    tick();
    nRST = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_out("ar_post", 1'b0, 32'h0);

    // final report
    chk("consumed_total", 64'(consumed), 64'd10);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
